// File: rtl/seq_alu_core.sv
// Multi-cycle ALU: registered operands, eight ops on a start/done handshake,
// iterative shift-add multiply, registered 2*WIDTH result with flag and overflow.
module seq_alu_core #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               load_a,
  input  logic               load_b,
  input  logic [2:0]         op,
  input  logic [1:0]         flag_sel,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               flag,
  output logic               overflow,
  output logic [1:0]         state_dbg
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SHR = 3'b010;
  localparam logic [2:0] OP_SHL = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [1:0]           flag_sel_q;
  logic [2*WIDTH-1:0]   acc_q, mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 flag_q, overflow_q;

  logic [WIDTH:0]       sum_w, diff_w;
  logic [2*WIDTH-1:0]   alu_res, acc_d;
  logic                 alu_ovf;

  function automatic logic flag_eval(input logic [1:0] sel,
                                     input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b);
    case (sel)
      2'b00:   return a > b;
      2'b01:   return a == b;
      2'b10:   return a == '0;
      default: return ~a[0];
    endcase
  endfunction

  // Single-cycle datapath, always fed by the registered operands so a load in
  // the start cycle does not affect the operation.
  always_comb begin
    sum_w   = {1'b0, a_q} + {1'b0, b_q};
    diff_w  = {1'b0, a_q} - {1'b0, b_q};
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_ADD: begin alu_res[WIDTH:0] = sum_w;                 alu_ovf = sum_w[WIDTH]; end
      OP_SUB: begin alu_res[WIDTH-1:0] = diff_w[WIDTH-1:0];   alu_ovf = diff_w[WIDTH]; end
      OP_SHR: begin alu_res[WIDTH-1:0] = {1'b0, a_q[WIDTH-1:1]}; alu_ovf = a_q[0]; end
      OP_SHL: begin alu_res[WIDTH-1:0] = {a_q[WIDTH-2:0], 1'b0}; alu_ovf = a_q[WIDTH-1]; end
      OP_AND: alu_res[WIDTH-1:0] = a_q & b_q;
      OP_OR:  alu_res[WIDTH-1:0] = a_q | b_q;
      OP_XOR: alu_res[WIDTH-1:0] = a_q ^ b_q;
      default: alu_res = '0;
    endcase
  end

  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      flag_sel_q <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      flag_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_a) a_q <= in_data;
          if (load_b) b_q <= in_data;
          if (start) begin
            flag_sel_q <= flag_sel;
            if (op == OP_MUL) begin
              acc_q    <= '0;
              mcand_q  <= {{WIDTH{1'b0}}, a_q};
              mplier_q <= b_q;
              cnt_q    <= '0;
              state_q  <= S_MUL;
            end else begin
              result_q   <= alu_res;
              overflow_q <= alu_ovf;
              flag_q     <= flag_eval(flag_sel, a_q, b_q);
              state_q    <= S_DONE;
            end
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          // Operands are frozen while busy, so the flag can be evaluated at the end.
          if (cnt_q == CNT_LAST) begin
            result_q   <= acc_d;
            overflow_q <= |acc_d[2*WIDTH-1:WIDTH];
            flag_q     <= flag_eval(flag_sel_q, a_q, b_q);
            state_q    <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Handshake: start is honoured only in IDLE; done is high for the single
  // cycle spent in DONE, on the same edge result/flag/overflow change.
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign flag      = flag_q;
  assign overflow  = overflow_q;
  assign state_dbg = state_q;

endmodule
